// File: rtl/junction_controller.sv
// Crossroads signal sequencer: two UK-style heads, all-red interlocks and a latched pedestrian walk phase.
// Optional night amber flash is compiled in when NIGHT_FLASH_EN is defined.
module junction_controller #(
    parameter int T_GREEN    = 20,
    parameter int T_AMBER    = 3,
    parameter int T_REDAMBER = 2,
    parameter int T_ALLRED   = 2,
    parameter int T_WALK     = 10,
    parameter int T_FLASH    = 4,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ped_req,
    input  logic night,
    output logic ns_r,
    output logic ns_a,
    output logic ns_g,
    output logic ew_r,
    output logic ew_a,
    output logic ew_g,
    output logic ped_walk,
    output logic ped_wait
);

    typedef enum logic [3:0] {
        AR_NS,
        NS_RA,
        NS_G,
        NS_A,
        AR_EW,
        EW_RA,
        EW_G,
        EW_A,
        WALK
`ifdef NIGHT_FLASH_EN
        , FLASH
`endif
    } state_t;

    typedef struct packed {
        logic ns_r;
        logic ns_a;
        logic ns_g;
        logic ew_r;
        logic ew_a;
        logic ew_g;
        logic walk;
    } lamps_t;

    localparam lamps_t ALL_RED = '{ns_r: 1'b1, ew_r: 1'b1, default: 1'b0};

    // Dwell limits stored as "last count" so the compare is a plain equality.
    localparam logic [CNT_W-1:0] LAST_GREEN    = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LAST_AMBER    = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] LAST_REDAMBER = CNT_W'(T_REDAMBER - 1);
    localparam logic [CNT_W-1:0] LAST_ALLRED   = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LAST_WALK     = CNT_W'(T_WALK - 1);
`ifdef NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] LAST_FLASH    = CNT_W'(T_FLASH - 1);
`endif

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_last;
    logic               done;
    logic               ped_wait_next;
    logic               next_ew, next_ew_next;
    lamps_t             lamps, lamps_next;
    logic               phase_next;

`ifdef NIGHT_FLASH_EN
    logic               phase;
`else
    logic               unused_cfg;
    assign unused_cfg = night & (T_FLASH != 0);
    assign phase_next = 1'b0;
`endif

    // State register: every flop, including the lamp drivers, returns to the all-red rest state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            // NOTE: reset is synchronous; every register here is control state, so all are reset.
            state    <= AR_NS;
            cnt      <= '0;
            ped_wait <= 1'b0;
            next_ew  <= 1'b0;
            lamps    <= ALL_RED;
`ifdef NIGHT_FLASH_EN
            phase    <= 1'b1;
`endif
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ped_wait <= ped_wait_next;
            next_ew  <= next_ew_next;
            lamps    <= lamps_next;
`ifdef NIGHT_FLASH_EN
            phase    <= phase_next;
`endif
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        cnt_last = LAST_ALLRED;
        case (state)
            NS_RA, EW_RA: cnt_last = LAST_REDAMBER;
            NS_G,  EW_G:  cnt_last = LAST_GREEN;
            NS_A,  EW_A:  cnt_last = LAST_AMBER;
            WALK:         cnt_last = LAST_WALK;
`ifdef NIGHT_FLASH_EN
            FLASH:        cnt_last = LAST_FLASH;
`endif
            default:      cnt_last = LAST_ALLRED;
        endcase
    end

    assign done = (cnt == cnt_last);

    // Next-state logic: transitions only on the final count of a dwell.
    always_comb begin
        state_next = state;
        if (done) begin
            case (state)
                AR_NS, AR_EW: begin
                    if (ped_wait)
                        state_next = WALK;
`ifdef NIGHT_FLASH_EN
                    else if (night)
                        state_next = FLASH;
`endif
                    else if (state == AR_NS)
                        state_next = NS_RA;
                    else
                        state_next = EW_RA;
                end
                NS_RA:   state_next = NS_G;
                NS_G:    state_next = NS_A;
                NS_A:    state_next = AR_EW;
                EW_RA:   state_next = EW_G;
                EW_G:    state_next = EW_A;
                EW_A:    state_next = AR_NS;
                WALK:    state_next = next_ew ? EW_RA : NS_RA;
`ifdef NIGHT_FLASH_EN
                FLASH:   if (!phase && !night) state_next = AR_NS;
`endif
                default: state_next = AR_NS;
            endcase
        end
    end

    // Counter and side registers; the flash half-period reuses the dwell counter.
    always_comb begin
        cnt_next      = done ? '0 : cnt + 1'b1;
        ped_wait_next = ped_wait;
        next_ew_next  = next_ew;

        if (state != WALK && ped_req)
            ped_wait_next = 1'b1;
        if (state != WALK && state_next == WALK)
            ped_wait_next = 1'b0;

        // Remember which head the all-red was leading into, so WALK can resume it.
        if (done && (state == AR_NS || state == AR_EW))
            next_ew_next = (state == AR_EW);
    end

`ifdef NIGHT_FLASH_EN
    always_comb begin
        phase_next = phase;
        if (state == FLASH && done)
            phase_next = ~phase;
        if (state != FLASH && state_next == FLASH)
            phase_next = 1'b1;
    end
`endif

    // Output decode from the next state so registered lamps line up with the state they show.
    always_comb begin
        lamps_next = ALL_RED;
        case (state_next)
            NS_RA: lamps_next.ns_a = 1'b1;
            NS_G: begin
                lamps_next.ns_r = 1'b0;
                lamps_next.ns_g = 1'b1;
            end
            NS_A: begin
                lamps_next.ns_r = 1'b0;
                lamps_next.ns_a = 1'b1;
            end
            EW_RA: lamps_next.ew_a = 1'b1;
            EW_G: begin
                lamps_next.ew_r = 1'b0;
                lamps_next.ew_g = 1'b1;
            end
            EW_A: begin
                lamps_next.ew_r = 1'b0;
                lamps_next.ew_a = 1'b1;
            end
            WALK: lamps_next.walk = 1'b1;
`ifdef NIGHT_FLASH_EN
            FLASH: begin
                lamps_next.ns_r = 1'b0;
                lamps_next.ew_r = 1'b0;
                lamps_next.ns_a = phase_next;
                lamps_next.ew_a = phase_next;
            end
`endif
            default: lamps_next = ALL_RED;
        endcase
    end

    assign ns_r     = lamps.ns_r;
    assign ns_a     = lamps.ns_a;
    assign ns_g     = lamps.ns_g;
    assign ew_r     = lamps.ew_r;
    assign ew_a     = lamps.ew_a;
    assign ew_g     = lamps.ew_g;
    assign ped_walk = lamps.walk;

endmodule

// File: tb/tb_junction_controller.sv
// Bench for junction_controller (default build): a phase/countdown model checked every cycle,
// plus literal lamp patterns at hand-computed cycle numbers.
module tb_junction_controller;

    localparam int T_GREEN    = 20;
    localparam int T_AMBER    = 3;
    localparam int T_REDAMBER = 2;
    localparam int T_ALLRED   = 2;
    localparam int T_WALK     = 10;

    logic clk, rst_n, ped_req, night;
    logic ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, ped_walk, ped_wait;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    junction_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ped_req  (ped_req),
        .night    (night),
        .ns_r     (ns_r),
        .ns_a     (ns_a),
        .ns_g     (ns_g),
        .ew_r     (ew_r),
        .ew_a     (ew_a),
        .ew_g     (ew_g),
        .ped_walk (ped_walk),
        .ped_wait (ped_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase index into the eight-phase ring, remaining cycles, walk flag and latched request.
    int dur [8] = '{T_ALLRED, T_REDAMBER, T_GREEN, T_AMBER, T_ALLRED, T_REDAMBER, T_GREEN, T_AMBER};
    int m_p, m_rem, m_after;
    bit m_walk, m_wait, m_nw;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_p = 0; m_rem = T_ALLRED; m_walk = 0; m_wait = 0; m_after = 1; m_valid = 1;
        end else if (m_valid) begin
            m_nw = m_wait | (ped_req & !m_walk);
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                if (m_walk) begin
                    m_walk = 0;
                    m_p = m_after;
                end else if ((m_p % 4 == 0) && m_wait) begin
                    m_walk = 1;
                    m_after = m_p + 1;
                    m_nw = 0;
                end else begin
                    m_p = (m_p + 1) % 8;
                end
                m_rem = m_walk ? T_WALK : dur[m_p];
            end
            m_wait = m_nw;
        end
    end

    function automatic logic [2:0] head(input int idx);
        case (idx)
            1:       return 3'b110;
            2:       return 3'b001;
            3:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] model_lamps();
        logic [2:0] ns, ew;
        ns = m_walk ? 3'b100 : ((m_p < 4) ? head(m_p) : 3'b100);
        ew = m_walk ? 3'b100 : ((m_p >= 4) ? head(m_p - 4) : 3'b100);
        return {ns, ew, m_walk, m_wait};
    endfunction

    function automatic logic [7:0] dut_lamps();
        return {ns_r, ns_a, ns_g, ew_r, ew_a, ew_g, ped_walk, ped_wait};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %b expected %b (ns_rag ew_rag walk wait)", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid)
            check("cycle_vs_model", dut_lamps(), model_lamps());
    end

    task automatic step();
        @(posedge clk);
        #3;
        k++;
        night = ~night;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic check_lamps(input string name, input logic [7:0] exp);
        check({name, "_dut"}, dut_lamps(), exp);
        check({name, "_model"}, model_lamps(), exp);
    endtask

    initial begin
        rst_n = 1'b0; ped_req = 1'b0; night = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #3;
        end
        rst_n = 1'b1;
        k = 0;

        // Plain cycle, night toggling throughout
        check_lamps("reset_state", 8'b100_100_00);
        run_to(2);  check_lamps("ns_redamber", 8'b110_100_00);
        run_to(4);  check_lamps("ns_green_first", 8'b001_100_00);
        run_to(23); check_lamps("ns_green_last", 8'b001_100_00);
        run_to(24); check_lamps("ns_amber", 8'b010_100_00);
        run_to(27); check_lamps("allred_ew", 8'b100_100_00);
        run_to(29); check_lamps("ew_redamber", 8'b100_110_00);
        run_to(31); check_lamps("ew_green", 8'b100_001_00);
        run_to(51); check_lamps("ew_amber", 8'b100_010_00);
        run_to(54); check_lamps("allred_ns_wrap", 8'b100_100_00);
        run_to(56); check_lamps("period_54", 8'b110_100_00);

        // Single-cycle request during NS_G
        run_to(60); ped_req = 1'b1; step(); ped_req = 1'b0;
        check_lamps("pulse_latched", 8'b001_100_01);
        run_to(82); check_lamps("wait_before_walk", 8'b100_100_01);
        run_to(83); check_lamps("walk_start", 8'b100_100_10);
        run_to(92); check_lamps("walk_end", 8'b100_100_10);
        run_to(93); check_lamps("ew_after_walk", 8'b100_110_00);
        run_to(120); check_lamps("no_second_walk", 8'b110_100_00);

        // Request held through WALK
        run_to(122); ped_req = 1'b1;
        run_to(147); check_lamps("held_walk_start", 8'b100_100_10);
        run_to(156); check_lamps("held_walk_end", 8'b100_100_10);
        run_to(157); check_lamps("held_exit_edge", 8'b100_110_00);
        run_to(158); check_lamps("held_relatch", 8'b100_110_01);
        ped_req = 1'b0;
        run_to(184); check_lamps("relatched_walk", 8'b100_100_10);
        run_to(194); check_lamps("ns_after_walk", 8'b110_100_00);
        run_to(221); check_lamps("ew_no_walk", 8'b100_110_00);

        // Request on the final AR_NS cycle
        run_to(247); ped_req = 1'b1; step(); ped_req = 1'b0;
        check_lamps("late_req_no_walk", 8'b110_100_01);
        run_to(275); check_lamps("late_req_served", 8'b100_100_10);
        run_to(285); check_lamps("late_req_ew", 8'b100_110_00);

        // Reset during EW_G with a pending request
        run_to(290); ped_req = 1'b1; step(); ped_req = 1'b0;
        check_lamps("pending_in_ew_g", 8'b100_001_01);
        run_to(295); rst_n = 1'b0; step(); rst_n = 1'b1;
        check_lamps("mid_reset", 8'b100_100_00);
        run_to(298); check_lamps("restart_ns_ra", 8'b110_100_00);
        run_to(300); check_lamps("restart_ns_g", 8'b001_100_00);
        run_to(360);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
